// File: rtl/color_led_scan_toggle_if.sv
// Front-panel key matrix / colour-LED bundle.
//   i_sense     : column sense from the matrix, active-low, asynchronous
//   i_mode      : 0 = toggle on press, 1 = momentary
//   i_clear     : turn every LED off on the next edge
//   o_scan      : one-hot-low row drive
//   o_led       : LED state per key, active-low, bit = row*N_COLS+col
//   o_press     : one-cycle strobe on a debounced press
//   o_press_idx : index of the pressed key (lowest column on a tie)
// master = panel/controller side, slave = the scan/toggle block.
interface color_led_scan_toggle_if #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 3,
  parameter int IDX_W  = $clog2(N_ROWS*N_COLS)
);
  logic [N_COLS-1:0]        i_sense;
  logic                     i_mode;
  logic                     i_clear;
  logic [N_ROWS-1:0]        o_scan;
  logic [N_ROWS*N_COLS-1:0] o_led;
  logic                     o_press;
  logic [IDX_W-1:0]         o_press_idx;

  modport master (
    output i_sense, i_mode, i_clear,
    input  o_scan, o_led, o_press, o_press_idx
  );

  modport slave (
    input  i_sense, i_mode, i_clear,
    output o_scan, o_led, o_press, o_press_idx
  );
endinterface

// File: rtl/color_led_scan_toggle.sv
// Colour-LED key matrix scanner with per-key debounce and LED latches.
// Drives the row scan, synchronises the column sense lines, debounces each
// key at its row's sample point and keeps one active-low LED bit per key,
// either toggled on press or following the key (momentary).
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : color_led_scan_toggle_if.slave (sense/mode/clear in,
//         scan/led/press/press_idx out)
module color_led_scan_toggle #(
  parameter int N_ROWS   = 4,
  parameter int N_COLS   = 3,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int IDX_W    = $clog2(N_ROWS*N_COLS)
) (
  input  logic clk,
  input  logic rst,
  color_led_scan_toggle_if.slave bus
);

  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  logic [DIV_W-1:0]  div;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_nxt;
  logic [N_ROWS-1:0] scan;
  logic              sample_pt;

  logic [N_COLS-1:0] sense_p0;
  logic [N_COLS-1:0] sense_p1;

  logic [N_KEYS-1:0] db;
  logic [N_KEYS-1:0] db_nxt;
  logic [N_KEYS-1:0] press_hit;
  logic [N_KEYS-1:0] led;
  logic [N_KEYS-1:0] led_nxt;
  logic              press;
  logic [IDX_W-1:0]  press_idx;
  logic [IDX_W-1:0]  idx_chain [N_KEYS+1];

  assign sample_pt = (div == DIV_W'(SCAN_DIV - 1));
  assign row_nxt   = (row == ROW_W'(N_ROWS - 1)) ? '0 : row + ROW_W'(1);

  // Per-key debounce: each key only sees its own row's sample point.
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    localparam int R = k / N_COLS;
    localparam int C = k % N_COLS;
    logic             hit;
    logic             smp;
    logic             differ;
    logic             commit;
    logic [CNT_W-1:0] cnt;

    assign hit    = sample_pt && (row == ROW_W'(R));
    assign smp    = sense_p1[C];
    assign differ = (smp != db[k]);
    assign commit = hit && differ && (cnt == CNT_W'(DEBOUNCE - 1));

    assign db_nxt[k]    = commit ? smp : db[k];
    assign press_hit[k] = commit && !smp;

    // Lowest pressed key wins: scan the chain from the top down.
    assign idx_chain[k] = press_hit[k] ? IDX_W'(k) : idx_chain[k+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (hit) begin
        cnt <= (differ && !commit) ? cnt + CNT_W'(1) : '0;
      end
    end
  end

  assign idx_chain[N_KEYS] = '0;

  // Clear beats everything; momentary mode tracks the debounced state
  // every cycle, so a held key relights right after a clear.
  always_comb begin
    led_nxt = led ^ press_hit;
    if (bus.i_clear) begin
      led_nxt = '1;
    end else if (bus.i_mode) begin
      led_nxt = db_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      row       <= '0;
      scan      <= ~N_ROWS'(1);
      sense_p0  <= '1;
      sense_p1  <= '1;
      db        <= '1;
      led       <= '1;
      press     <= 1'b0;
      press_idx <= '0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser on the sense columns
      sense_p0 <= bus.i_sense;
      sense_p1 <= sense_p0;
      if (sample_pt) begin
        div  <= '0;
        row  <= row_nxt;
        scan <= ~(N_ROWS'(1) << row_nxt);
      end else begin
        div  <= div + DIV_W'(1);
      end
      // debounce commit -> LED / strobe register
      db        <= db_nxt;
      led       <= led_nxt;
      press     <= |press_hit;
      press_idx <= idx_chain[0];
    end
  end

  assign bus.o_scan      = scan;
  assign bus.o_led       = led;
  assign bus.o_press     = press;
  assign bus.o_press_idx = press_idx;

endmodule

// File: tb/tb_color_led_scan_toggle.sv
// Self-checking bench for color_led_scan_toggle: a virtual key matrix drives
// the sense lines from the expected row, and a cycle-level reference model
// (time-derived row, integer debounce counters) predicts every output.
module tb_color_led_scan_toggle;
  localparam int NR = 4;
  localparam int NC = 3;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int NK = NR * NC;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_led_scan_toggle_if #(.N_ROWS(NR), .N_COLS(NC), .IDX_W(IW)) bus ();

  color_led_scan_toggle #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB), .IDX_W(IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int            edges;
  logic [NC-1:0] m_s1, m_s2;
  bit            deb [NK];
  int            cnt [NK];
  logic [NK-1:0] m_led;
  bit            m_press;
  int            m_idx;

  // stimulus controls
  logic [NK-1:0] keys;
  bit            mode, clr_r2, rand_clr;

  function automatic int cur_row();
    return (edges / SD) % NR;
  endfunction

  function automatic logic [NC-1:0] matrix();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = !keys[cur_row()*NC + c];
    return v;
  endfunction

  task automatic model_reset();
    edges = 0; m_s1 = '1; m_s2 = '1;
    for (int k = 0; k < NK; k++) begin deb[k] = 1'b1; cnt[k] = 0; end
    m_led = '1; m_press = 1'b0; m_idx = 0;
  endtask

  task automatic model_edge(input logic [NC-1:0] sin, input bit clr_now);
    logic [NC-1:0] s;
    logic [NK-1:0] pressed;
    s = m_s2; m_s2 = m_s1; m_s1 = sin;
    pressed = '0;
    if (edges % SD == SD - 1) begin
      for (int c = 0; c < NC; c++) begin
        int k;
        k = cur_row()*NC + c;
        if (s[c] == deb[k]) cnt[k] = 0;
        else begin
          cnt[k]++;
          if (cnt[k] == DB) begin
            deb[k] = s[c]; cnt[k] = 0;
            if (!s[c]) pressed[k] = 1'b1;
          end
        end
      end
    end
    m_press = (pressed != 0);
    for (int k = NK - 1; k >= 0; k--) if (pressed[k]) m_idx = k;
    if (clr_now) m_led = '1;
    else if (mode) for (int k = 0; k < NK; k++) m_led[k] = deb[k];
    else m_led = m_led ^ pressed;
    edges++;
  endtask

  task automatic check_outs();
    logic [NR-1:0] es;
    es = ~(NR'(1) << cur_row());
    chk("scan", bus.o_scan, es);
    chk("led", bus.o_led, m_led);
    chk("press", bus.o_press, m_press);
    if (m_press) chk("press_idx", bus.o_press_idx, m_idx);
  endtask

  task automatic step();
    logic [NC-1:0] sin;
    bit clr_now;
    sin = matrix();
    clr_now = (clr_r2 && (edges % SD == SD - 1) && cur_row() == 2) ||
              (rand_clr && $urandom_range(0, 29) == 0);
    bus.i_sense = sin;
    bus.i_mode  = mode;
    bus.i_clear = clr_now;
    @(posedge clk);
    model_edge(sin, clr_now);
    #1;
    check_outs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; keys = '0; mode = 1'b0; clr_r2 = 1'b0; rand_clr = 1'b0;
    bus.i_sense = '1; bus.i_mode = 1'b0; bus.i_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_scan", bus.o_scan, 4'b1110);
    chk("rst_led", bus.o_led, 12'hFFF);
    chk("rst_press", bus.o_press, 1'b0);
    chk("rst_idx", bus.o_press_idx, 0);
    rst = 1'b0;

    run(32);                                   // idle frames
    chk("idle_led", bus.o_led, 12'hFFF);

    keys = NK'(1) << 7; run(48);               // toggle on
    chk("tog_on", bus.o_led, 12'hF7F);
    keys = '0; run(48);                        // release leaves LED lit
    chk("tog_rel", bus.o_led, 12'hF7F);
    keys = NK'(1) << 7; run(48);               // toggle off
    chk("tog_off", bus.o_led, 12'hFFF);
    keys = '0; run(48);

    keys = NK'(1) << 7; run(32);               // bounce: 2 frames only
    keys = '0; run(16);
    keys = NK'(1) << 7; run(32);
    chk("bounce", bus.o_led, 12'hFFF);
    run(16);
    chk("bounce_commit", bus.o_led, 12'hF7F);
    keys = '0; run(48);

    mode = 1'b1; keys = NK'(1); run(48);       // momentary
    chk("mom_on", bus.o_led, 12'hFFE);
    keys = '0; run(48);
    chk("mom_off", bus.o_led, 12'hFFF);

    mode = 1'b0; keys = (NK'(1) << 3) | (NK'(1) << 5); run(48);
    chk("simul", bus.o_led, 12'hFD7);
    keys = '0; run(48);

    keys = NK'(1) << 7; clr_r2 = 1'b1; run(48); // clear on the commit cycle
    chk("clr_commit", bus.o_led, 12'hFFF);
    clr_r2 = 1'b0; keys = '0; run(48);

    keys = NK'(1) << 7; run(32);               // reset mid-debounce
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_scan", bus.o_scan, 4'b1110);
    chk("mid_rst_led", bus.o_led, 12'hFFF);
    chk("mid_rst_press", bus.o_press, 1'b0);
    #1 rst = 1'b0;
    run(32);
    chk("post_rst_2fr", bus.o_led, 12'hFFF);
    run(16);
    chk("post_rst_3fr", bus.o_led, 12'hF7F);
    keys = '0; run(48);

    rand_clr = 1'b1;                           // randomized segments
    repeat (30) begin
      keys = NK'($urandom_range(0, 4095) & $urandom_range(0, 4095) & $urandom_range(0, 4095));
      mode = ($urandom_range(0, 3) == 0);
      run($urandom_range(1, 64));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/color_led_scan_toggle.md
Name: color_led_scan_toggle

Overview:
- Parametrised successor to the colour-LED toggle latches: drives the button-matrix scan itself and stores one active-low LED state per matrix key.
- Sense inputs are synchronised and debounced per key. Each key controls its LED in one of two modes: toggle on press, or momentary.
- Sits between the front-panel key matrix (scan outputs, sense inputs) and the colour-LED drivers.

Parameters:
- N_ROWS, 4, number of scan rows driven low one at a time
- N_COLS, 3, number of sense columns
- SCAN_DIV, 4, clock cycles each row stays active; minimum 3
- DEBOUNCE, 3, consecutive identical per-key samples needed to change debounced state; minimum 1
- IDX_W, $clog2(N_ROWS*N_COLS), key index width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_sense  in  N_COLS  column sense, active-low (0 = pressed), asynchronous to clk
- i_mode  in  1  0 = toggle, 1 = momentary; global, read every cycle
- i_clear  in  1  synchronous: all LEDs off
- o_scan  out  N_ROWS  one-hot-low row drive
- o_led  out  N_ROWS*N_COLS  LED state per key, active-low (1 = off); bit = row*N_COLS+col
- o_press  out  1  one-cycle strobe on a debounced press
- o_press_idx  out  IDX_W  key index of the press; valid while o_press=1

Behaviour:
- Reset (async, rst=1) sets:
  - row=0, divider=0, o_scan = all 1 except bit0=0
  - o_led = all 1 (off); all debounced states = released (1); all debounce counters = 0
  - sync flops = 1; o_press=0, o_press_idx=0
- Scan:
  - divider counts 0..SCAN_DIV-1 and wraps.
  - When divider==SCAN_DIV-1, row advances; row N_ROWS-1 wraps to 0.
  - o_scan is registered: o_scan = ~(1<<row).
  - One frame = N_ROWS*SCAN_DIV cycles.
- Sync: i_sense passes through a 2-flop synchroniser, giving s_sense.
- Sample point: the cycle where divider==SCAN_DIV-1. s_sense[c] is applied to key row*N_COLS+c. Only the active row's keys are sampled, once per frame each.
- Debounce, per key, at its sample point:
  - If sample == debounced state: counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE, debounced state takes the sample and the counter clears.
  - DEBOUNCE=1 means a single differing sample commits.
- Press event: debounced state goes 1->0. Release event: 0->1. Both are registered, visible the cycle after the sample point.
- Toggle mode (i_mode=0):
  - On a press event, that key's o_led bit inverts. This is updated in the same cycle o_press is asserted.
  - Release events do not change o_led.
- Momentary mode (i_mode=1):
  - o_led bit follows that key's debounced state (pressed -> 0 = lit), registered.
  - Switching modes does not change o_led until the next event for that key. Exception: momentary mode re-evaluates continuously.
- i_clear:
  - Forces o_led to all 1 on the next edge.
  - Has priority over a toggle in the same cycle; the press strobe still fires.
  - In momentary mode, a held key relights on the following cycle.
- o_press / o_press_idx:
  - o_press is 1 for exactly one cycle per sample point with at least one press event.
  - If several columns of one row commit together, o_press_idx reports the lowest column. All of those LEDs still toggle.
- Latency from a committed sample to LED change / strobe: 1 cycle. Latency from an i_sense change to first sampling: at least 2 cycles plus the wait to that row's sample point.
- Reset mid-operation: immediate return to reset values. A partially debounced press is discarded.
- Widths: divider $clog2(SCAN_DIV); row $clog2(N_ROWS), minimum 1 bit; debounce counter $clog2(DEBOUNCE+1). Counters never exceed their terminal values.

Test Plan:
- Defaults, no keys pressed: o_scan cycles 1110,1101,1011,0111 with 4 cycles per row, repeating every 16 cycles. o_led stays 12'hFFF and o_press never asserts.
- Toggle press: hold i_sense[1]=0 only while row 2 is active, for 3 frames. One o_press pulse with o_press_idx=7; o_led bit7=0, all others 1. A second debounced press sets bit7 back to 1.
- Bounce: key 7 low for 2 frames, then high. No o_press and o_led unchanged. The counter resets, so a following 3-frame press is needed to commit.
- Momentary (i_mode=1): hold key 0 for 3 frames, then o_led[0]=0 with o_press idx 0. Release for 3 frames, then o_led[0]=1 and no strobe.
- Simultaneous events:
  - Keys 3 and 5 commit in the same sample: one o_press pulse, idx=3, o_led bits 3 and 5 both 0.
  - i_clear asserted in the same cycle as a toggle commit: o_led=12'hFFF and o_press still 1.
- Async reset asserted mid-debounce (2 of 3 frames done), then released: o_scan=1110 and o_led=12'hFFF immediately. A full 3 frames are then required before any press registers.
